// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - square-wave half-period to {keys, octave} decoder with lock filter
// Optional hysteresis build: define TONE_DEC_HYST_EN.
module tone_decoder #(
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        tone_in,
    output logic [11:0] keys_out,
    output logic [3:0]  octave_out,
    output logic        valid,
    output logic        overrun
);

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_NORM, S_CLASSIFY} state_t;

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            p_q, p_d;
    logic [3:0]             k_q, k_d;
    logic [3:0]             lock_q, lock_d;
    logic [3:0]             cand_note_q, cand_note_d;
    logic [3:0]             cand_oct_q, cand_oct_d;
    logic [11:0]            keys_q, keys_d;
    logic [3:0]             oct_q, oct_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;

    logic                   tone_edge;
    logic                   sample_ok;
    logic                   sample_bad;
    logic [3:0]             new_note;

    // Nearest-note lookup: thresholds are floored midpoints of adjacent normalized periods.
    function automatic logic [3:0] classify(input logic [15:0] p);
        if      (p > 16'd60746) return 4'd0;
        else if (p > 16'd57336) return 4'd1;
        else if (p > 16'd54118) return 4'd2;
        else if (p > 16'd51081) return 4'd3;
        else if (p > 16'd48214) return 4'd4;
        else if (p > 16'd45508) return 4'd5;
        else if (p > 16'd42953) return 4'd6;
        else if (p > 16'd40543) return 4'd7;
        else if (p > 16'd38268) return 4'd8;
        else if (p > 16'd36120) return 4'd9;
        else if (p > 16'd34092) return 4'd10;
        else                    return 4'd11;
    endfunction

    assign tone_edge = sync_q[SYNC_STAGES-1] ^ last_q;
    assign new_note  = classify(p_q);

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], tone_in};
        last_d      = sync_q[SYNC_STAGES-1];
        cnt_d       = cnt_q;
        p_d         = p_q;
        k_d         = k_q;
        lock_d      = lock_q;
        cand_note_d = cand_note_q;
        cand_oct_d  = cand_oct_q;
        keys_d      = keys_q;
        oct_d       = oct_q;
        valid_d     = valid_q;
        ovr_d       = 1'b0;
        sample_ok   = 1'b0;
        sample_bad  = 1'b0;

        if (state_q != S_IDLE && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (tone_edge) begin
            cnt_d = 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (tone_edge) state_d = S_MEASURE;
            end
            S_MEASURE: begin
                if (tone_edge) begin
                    p_d     = cnt_q;
                    k_d     = 4'd0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (tone_edge) begin
                    ovr_d      = 1'b1;
                    sample_bad = 1'b1;
                    state_d    = S_MEASURE;
                end else if (p_q[15]) begin
                    state_d = S_CLASSIFY;
                end else if (k_q != 4'd15) begin
                    p_d = p_q << 1;
                    k_d = k_q + 4'd1;
                end else begin
                    sample_bad = 1'b1;
                    state_d    = S_MEASURE;
                end
            end
            S_CLASSIFY: begin
                if (tone_edge) begin
                    ovr_d      = 1'b1;
                    sample_bad = 1'b1;
                end else begin
                    sample_ok = 1'b1;
                end
                state_d = S_MEASURE;
            end
            default: state_d = S_IDLE;
        endcase

        if (sample_ok) begin
            if (lock_q != 4'd0 && new_note == cand_note_q && k_q == cand_oct_q) begin
                lock_d = (lock_q >= LOCK_MAX) ? LOCK_MAX : lock_q + 4'd1;
            end else begin
                lock_d      = 4'd1;
                cand_note_d = new_note;
                cand_oct_d  = k_q;
`ifndef TONE_DEC_HYST_EN
                valid_d = 1'b0;
                keys_d  = 12'd0;
                oct_d   = 4'd0;
`endif
            end
            if (lock_d == LOCK_MAX) begin
                valid_d = 1'b1;
                keys_d  = 12'd1 << new_note;
                oct_d   = k_q;
            end
        end

        if (sample_bad) begin
            lock_d = 4'd0;
`ifndef TONE_DEC_HYST_EN
            valid_d = 1'b0;
            keys_d  = 12'd0;
            oct_d   = 4'd0;
`endif
        end

        // A saturated counter means the tone has stopped: drop everything and re-arm.
        if (cnt_q == 16'hFFFF && !tone_edge) begin
            state_d = S_IDLE;
            lock_d  = 4'd0;
            valid_d = 1'b0;
            keys_d  = 12'd0;
            oct_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            state_q     <= S_IDLE;
            sync_q      <= '0;
            last_q      <= 1'b0;
            cnt_q       <= 16'd0;
            p_q         <= 16'd0;
            k_q         <= 4'd0;
            lock_q      <= 4'd0;
            cand_note_q <= 4'd0;
            cand_oct_q  <= 4'd0;
            keys_q      <= 12'd0;
            oct_q       <= 4'd0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            k_q         <= k_d;
            lock_q      <= lock_d;
            cand_note_q <= cand_note_d;
            cand_oct_q  <= cand_oct_d;
            keys_q      <= keys_d;
            oct_q       <= oct_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign keys_out   = keys_q;
    assign octave_out = oct_q;
    assign valid      = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_tone_decoder.sv
// tb/tb_tone_decoder.sv - directed self-checking bench for tone_decoder
module tb_tone_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        tone_in = 1'b0;
    logic [11:0] keys_out;
    logic [3:0]  octave_out;
    logic        valid;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;
    logic ovr_seen  = 1'b0;
    logic saw_valid = 1'b0;
    logic saw_gap   = 1'b0;

    tone_decoder #(.LOCK_COUNT(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .tone_in    (tone_in),
        .keys_out   (keys_out),
        .octave_out (octave_out),
        .valid      (valid),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (overrun) ovr_seen = 1'b1;
            if (valid) saw_valid = 1'b1;
            else       saw_gap   = 1'b1;
        end
    endtask

    // First toggle after 'first' cycles, then n-1 more spaced 'half' cycles apart.
    task automatic toggle_run(input int first, input int half, input int n);
        step(first);
        tone_in = ~tone_in;
        for (int i = 1; i < n; i++) begin
            step(half);
            tone_in = ~tone_in;
        end
    endtask

    task automatic do_reset();
        tone_in = 1'b0;
        rst_n   = 1'b0;
        step(3);
        rst_n   = 1'b1;
        step(2);
    endtask

    initial begin
        do_reset();
        chk("rst_valid", valid, 0);
        chk("rst_keys", keys_out, 0);
        chk("rst_oct", octave_out, 0);
        chk("rst_ovr", overrun, 0);

        // A, octave 6: 581 << 6 = 37184
        toggle_run(10, 581, 4);
        step(40);
        chk("a_3samp_valid", valid, 0);
        toggle_run(541, 581, 1);
        step(40);
        chk("a_valid", valid, 1);
        chk("a_keys", keys_out, 12'h200);
        chk("a_oct", octave_out, 6);

        // Tone stops: decode holds until the counter saturates
        step(64960);
        chk("to_hold_valid", valid, 1);
        for (int i = 0; i < 1000 && valid; i++) step(1);
        chk("to_valid", valid, 0);
        chk("to_keys", keys_out, 0);
        chk("to_oct", octave_out, 0);

        // C, octave 6: 977 << 6 = 62528
        toggle_run(10, 977, 5);
        step(40);
        chk("c_valid", valid, 1);
        chk("c_keys", keys_out, 12'h001);
        chk("c_oct", octave_out, 6);

        // Switch to E, octave 6: 775 << 6 = 49600
        saw_gap = 1'b0;
        toggle_run(735, 775, 1);
        step(40);
`ifdef TONE_DEC_HYST_EN
        chk("e1_valid", valid, 1);
        chk("e1_keys", keys_out, 12'h001);
`else
        chk("e1_valid", valid, 0);
        chk("e1_keys", keys_out, 0);
`endif
        toggle_run(735, 775, 3);
        step(40);
        chk("e_valid", valid, 1);
        chk("e_keys", keys_out, 12'h010);
        chk("e_oct", octave_out, 6);
`ifdef TONE_DEC_HYST_EN
        chk("e_gap", saw_gap, 0);
`else
        chk("e_gap", saw_gap, 1);
`endif

        // Half-period 3: every sample is interrupted during normalization
        do_reset();
        ovr_seen  = 1'b0;
        saw_valid = 1'b0;
        toggle_run(5, 3, 30);
        step(40);
        chk("h3_overrun", ovr_seen, 1);
        chk("h3_saw_valid", saw_valid, 0);
        chk("h3_valid", valid, 0);
        saw_valid = 1'b0;
        toggle_run(5, 1, 30);
        step(60);
        chk("h1_saw_valid", saw_valid, 0);
        chk("h1_keys", keys_out, 0);

        // One-cycle reset mid-lock, then relock from scratch
        do_reset();
        toggle_run(10, 581, 6);
        step(40);
        chk("rl_pre_valid", valid, 1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("rl_rst_valid", valid, 0);
        chk("rl_rst_keys", keys_out, 0);
        chk("rl_rst_oct", octave_out, 0);
        toggle_run(10, 581, 4);
        step(40);
        chk("rl_3samp_valid", valid, 0);
        toggle_run(541, 581, 1);
        step(40);
        chk("rl_valid", valid, 1);
        chk("rl_keys", keys_out, 12'h200);

        ena = 1'b0;
        step(1);
        chk("ena_valid", valid, 0);
        chk("ena_keys", keys_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
